data_mem_ctrl: RTL and testbench

- Sequences and shares the 16-bit data SRAM (21-bit address, WE/CS/OE strobes) between two requesters.
  - Port A: core load/store unit.
  - Port B: DMA engine.
- Round-robin arbitration on a valid/ready request handshake.
- Drives the SRAM strobes through a setup/access/hold sequence with programmable wait states.
- Returns read data or a write acknowledge as a one-cycle response pulse to the granted requester.

---
 rtl/data_mem_pkg.sv | 8 +
 rtl/rr_arbiter2.sv | 20 ++
 rtl/data_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared widths and enums for the data SRAM controller.
package data_mem_pkg;
   localparam int ADDR_W = 21;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
   typedef enum logic {GNT_A, GNT_B} grant_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant; bit 0 = port A, bit 1 = port B.
module rr_arbiter2 import data_mem_pkg::*; (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);
   grant_t last_grant_q, last_grant_d;

   always_comb begin
      gnt = (req == 2'b11) ? ((last_grant_q == GNT_B) ? 2'b01 : 2'b10) : req;
      last_grant_d = !advance ? last_grant_q : gnt[1] ? GNT_B : gnt[0] ? GNT_A : last_grant_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) last_grant_q <= GNT_B;
      else last_grant_q <= last_grant_d;
   end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: shares the data SRAM between the core (A) and DMA (B) with a
// setup/access/hold strobe sequence and a one-cycle response pulse.
module data_mem_ctrl #(
   parameter int ADDR_W      = data_mem_pkg::ADDR_W,
   parameter int DATA_W      = data_mem_pkg::DATA_W,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req_valid,
   output logic              a_req_ready,
   input  logic              a_req_we,
   input  logic [ADDR_W-1:0] a_req_addr,
   input  logic [DATA_W-1:0] a_req_wdata,
   output logic              a_resp_valid,
   output logic [DATA_W-1:0] a_resp_rdata,
   input  logic              b_req_valid,
   output logic              b_req_ready,
   input  logic              b_req_we,
   input  logic [ADDR_W-1:0] b_req_addr,
   input  logic [DATA_W-1:0] b_req_wdata,
   output logic              b_resp_valid,
   output logic [DATA_W-1:0] b_resp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              mem_we,
   output logic              mem_cs,
   output logic              mem_oe,
   output logic              busy
);
   import data_mem_pkg::*;

   if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("data_mem_ctrl: WAIT_STATES must be within 1..15");
   end

   state_t              state_q, state_d;
   grant_t              gid_q, gid_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_din_q, mem_din_d;
   logic                mem_we_q, mem_we_d;
   logic                mem_cs_q, mem_cs_d;
   logic                mem_oe_q, mem_oe_d;
   logic                a_resp_valid_q, a_resp_valid_d;
   logic                b_resp_valid_q, b_resp_valid_d;
   logic [DATA_W-1:0]   a_resp_rdata_q, a_resp_rdata_d;
   logic [DATA_W-1:0]   b_resp_rdata_q, b_resp_rdata_d;
   logic [1:0]          gnt;
   logic                hs;
   logic                cap;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({b_req_valid, a_req_valid}),
      .advance (hs),
      .gnt     (gnt)
   );

   assign hs          = (state_q == IDLE) && (gnt != 2'b00);
   assign a_req_ready = (state_q == IDLE) && gnt[0];
   assign b_req_ready = (state_q == IDLE) && gnt[1];

   always_comb begin
      state_d = state_q;
      gid_d   = gid_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (hs) begin
            state_d = SETUP;
            gid_d   = gnt[1] ? GNT_B : GNT_A;
            we_d    = gnt[1] ? b_req_we : a_req_we;
            addr_d  = gnt[1] ? b_req_addr : a_req_addr;
            wdata_d = gnt[1] ? b_req_wdata : a_req_wdata;
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = 4'(WAIT_STATES - 1);
         end
         ACCESS: if (cnt_q == 4'd0) state_d = HOLD; else cnt_d = cnt_q - 4'd1;
         default: state_d = IDLE;
      endcase
      // Strobes are computed from the next state so they leave a flop aligned with it.
      mem_cs_d       = state_d != IDLE;
      mem_oe_d       = (state_d == SETUP || state_d == ACCESS) && !we_d;
      mem_we_d       = (state_d == ACCESS) && we_d;
      mem_addr_d     = addr_d;
      mem_din_d      = wdata_d;
      a_resp_valid_d = (state_d == HOLD) && (gid_d == GNT_A);
      b_resp_valid_d = (state_d == HOLD) && (gid_d == GNT_B);
      cap            = (state_q == ACCESS) && (cnt_q == 4'd0) && !we_q;
      a_resp_rdata_d = (cap && gid_q == GNT_A) ? mem_dout : a_resp_rdata_q;
      b_resp_rdata_d = (cap && gid_q == GNT_B) ? mem_dout : b_resp_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         gid_q          <= GNT_A;
         we_q           <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         cnt_q          <= '0;
         mem_addr_q     <= '0;
         mem_din_q      <= '0;
         mem_we_q       <= 1'b0;
         mem_cs_q       <= 1'b0;
         mem_oe_q       <= 1'b0;
         a_resp_valid_q <= 1'b0;
         b_resp_valid_q <= 1'b0;
         a_resp_rdata_q <= '0;
         b_resp_rdata_q <= '0;
      end else begin
         state_q        <= state_d;
         gid_q          <= gid_d;
         we_q           <= we_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         cnt_q          <= cnt_d;
         mem_addr_q     <= mem_addr_d;
         mem_din_q      <= mem_din_d;
         mem_we_q       <= mem_we_d;
         mem_cs_q       <= mem_cs_d;
         mem_oe_q       <= mem_oe_d;
         a_resp_valid_q <= a_resp_valid_d;
         b_resp_valid_q <= b_resp_valid_d;
         a_resp_rdata_q <= a_resp_rdata_d;
         b_resp_rdata_q <= b_resp_rdata_d;
      end
   end

   assign mem_addr     = mem_addr_q;
   assign mem_din      = mem_din_q;
   assign mem_we       = mem_we_q;
   assign mem_cs       = mem_cs_q;
   assign mem_oe       = mem_oe_q;
   assign a_resp_valid = a_resp_valid_q;
   assign b_resp_valid = b_resp_valid_q;
   assign a_resp_rdata = a_resp_rdata_q;
   assign b_resp_rdata = b_resp_rdata_q;
   assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of the SRAM controller with one and three wait states.
module tb_data_mem_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid;
   logic [20:0] a_req_addr;
   logic [15:0] a_req_wdata, a_resp_rdata;
   logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid;
   logic [20:0] b_req_addr;
   logic [15:0] b_req_wdata, b_resp_rdata;
   logic [20:0] mem_addr;
   logic [15:0] mem_din, mem_dout;
   logic        mem_we, mem_cs, mem_oe, busy;

   logic        a3_req_valid, a3_req_ready, a3_resp_valid;
   logic        a3_req_we = 1'b0;
   logic [20:0] a3_req_addr;
   logic [15:0] a3_req_wdata = 16'h0, a3_resp_rdata;
   logic        b3_req_valid = 1'b0, b3_req_we = 1'b0, b3_req_ready, b3_resp_valid;
   logic [20:0] b3_req_addr = 21'h0;
   logic [15:0] b3_req_wdata = 16'h0, b3_resp_rdata;
   logic [20:0] mem3_addr;
   logic [15:0] mem3_din, mem3_dout;
   logic        mem3_we, mem3_cs, mem3_oe, busy3;

   logic [15:0] sram [256];
   int checks = 0;
   int failures = 0;
   int n, oe_n;

   always #5 clk = ~clk;

   data_mem_ctrl #(.WAIT_STATES(1)) dut (
      .clk(clk), .reset(reset),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
      .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
      .a_resp_valid(a_resp_valid), .a_resp_rdata(a_resp_rdata),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
      .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
      .b_resp_valid(b_resp_valid), .b_resp_rdata(b_resp_rdata),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_we(mem_we), .mem_cs(mem_cs), .mem_oe(mem_oe), .busy(busy)
   );

   data_mem_ctrl #(.WAIT_STATES(3)) dut3 (
      .clk(clk), .reset(reset),
      .a_req_valid(a3_req_valid), .a_req_ready(a3_req_ready), .a_req_we(a3_req_we),
      .a_req_addr(a3_req_addr), .a_req_wdata(a3_req_wdata),
      .a_resp_valid(a3_resp_valid), .a_resp_rdata(a3_resp_rdata),
      .b_req_valid(b3_req_valid), .b_req_ready(b3_req_ready), .b_req_we(b3_req_we),
      .b_req_addr(b3_req_addr), .b_req_wdata(b3_req_wdata),
      .b_resp_valid(b3_resp_valid), .b_resp_rdata(b3_resp_rdata),
      .mem_addr(mem3_addr), .mem_din(mem3_din), .mem_dout(mem3_dout),
      .mem_we(mem3_we), .mem_cs(mem3_cs), .mem_oe(mem3_oe), .busy(busy3)
   );

   // Small SRAM model indexed by the low address byte; reloads its preset while reset is low.
   always @(posedge clk) begin
      if (!reset) sram[8'h10] <= 16'hBEEF;
      else if (mem_cs && mem_we) sram[mem_addr[7:0]] <= mem_din;
   end
   assign mem_dout = (mem_cs && mem_oe) ? sram[mem_addr[7:0]] : 16'h0000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0;
      b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0;
      a3_req_valid = 0; a3_req_addr = '0; mem3_dout = '0;
      repeat (3) tick();
      check("rst_cs", mem_cs, 0);
      check("rst_we", mem_we, 0);
      check("rst_oe", mem_oe, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_din", mem_din, 0);
      check("rst_busy", busy, 0);
      check("rst_arv", a_resp_valid, 0);
      check("rst_brv", b_resp_valid, 0);
      check("rst_ardata", a_resp_rdata, 0);
      reset = 1'b1;
      tick();
      check("idle_busy", busy, 0);
      check("idle_ardy", a_req_ready, 0);
      check("idle_brdy", b_req_ready, 0);
      check("idle_cs", mem_cs, 0);

      // one-cycle reset while A is requesting: nothing may be accepted
      a_req_valid = 1; reset = 1'b0;
      tick();
      reset = 1'b1; a_req_valid = 0;
      #1;
      check("rstpulse_busy", busy, 0);
      check("rstpulse_cs", mem_cs, 0);
      tick();
      check("rstpulse_busy2", busy, 0);

      // A read, one wait state
      a_req_valid = 1; a_req_we = 0; a_req_addr = 21'h00010;
      #1;
      check("ard_ardy", a_req_ready, 1);
      check("ard_brdy", b_req_ready, 0);
      tick();
      a_req_valid = 0;
      check("ard_setup_cs", mem_cs, 1);
      check("ard_setup_oe", mem_oe, 1);
      check("ard_setup_we", mem_we, 0);
      check("ard_setup_addr", mem_addr, 21'h00010);
      check("ard_setup_busy", busy, 1);
      tick();
      check("ard_acc_cs", mem_cs, 1);
      check("ard_acc_oe", mem_oe, 1);
      check("ard_acc_rv", a_resp_valid, 0);
      tick();
      check("ard_hold_cs", mem_cs, 1);
      check("ard_hold_oe", mem_oe, 0);
      check("ard_hold_rv", a_resp_valid, 1);
      check("ard_hold_rdata", a_resp_rdata, 16'hBEEF);
      check("ard_hold_brv", b_resp_valid, 0);
      tick();
      check("ard_end_cs", mem_cs, 0);
      check("ard_end_rv", a_resp_valid, 0);
      check("ard_end_busy", busy, 0);

      // B write to the top address
      b_req_valid = 1; b_req_we = 1; b_req_addr = 21'h1FFFFF; b_req_wdata = 16'h1234;
      #1;
      check("bwr_brdy", b_req_ready, 1);
      check("bwr_ardy", a_req_ready, 0);
      tick();
      b_req_valid = 0; b_req_we = 0; b_req_wdata = 16'h5555; b_req_addr = 21'h0;
      check("bwr_setup_we", mem_we, 0);
      check("bwr_setup_oe", mem_oe, 0);
      check("bwr_setup_cs", mem_cs, 1);
      check("bwr_setup_addr", mem_addr, 21'h1FFFFF);
      check("bwr_setup_din", mem_din, 16'h1234);
      tick();
      check("bwr_acc_we", mem_we, 1);
      check("bwr_acc_oe", mem_oe, 0);
      tick();
      check("bwr_hold_we", mem_we, 0);
      check("bwr_hold_cs", mem_cs, 1);
      check("bwr_hold_addr", mem_addr, 21'h1FFFFF);
      check("bwr_hold_din", mem_din, 16'h1234);
      check("bwr_hold_brv", b_resp_valid, 1);
      check("bwr_hold_arv", a_resp_valid, 0);
      check("bwr_hold_brdata", b_resp_rdata, 16'h0000);
      tick();
      check("bwr_end_brv", b_resp_valid, 0);

      // continuous contention: A, B, A, B every 4 cycles
      a_req_valid = 1; a_req_we = 0; a_req_addr = 21'h00010;
      b_req_valid = 1; b_req_we = 0; b_req_addr = 21'h1FFFFF;
      #1;
      n = 0;
      for (int c = 0; c < 16; c++) begin
         if (a_req_ready || b_req_ready) begin
            check($sformatf("rr_grant%0d", n), {a_req_ready, b_req_ready}, (n % 2 == 0) ? 2'b10 : 2'b01);
            check($sformatf("rr_cycle%0d", n), c, n * 4);
            n++;
         end
         tick();
      end
      a_req_valid = 0; b_req_valid = 0;
      check("rr_count", n, 4);
      check("rr_last_brdata", b_resp_rdata, 16'h1234);

      // read back the B write through A
      a_req_valid = 1; a_req_addr = 21'h1FFFFF;
      #1;
      check("rb_ardy", a_req_ready, 1);
      tick();
      a_req_valid = 0;
      tick(); tick();
      check("rb_rv", a_resp_valid, 1);
      check("rb_rdata", a_resp_rdata, 16'h1234);
      tick();

      // three wait states on the second instance; only the last ACCESS cycle's data counts
      a3_req_valid = 1; a3_req_addr = 21'h00020; mem3_dout = 16'h1111;
      #1;
      check("ws3_rdy", a3_req_ready, 1);
      tick();
      a3_req_valid = 0;
      oe_n = 0;
      for (int c = 1; c <= 6; c++) begin
         mem3_dout = (c == 4) ? 16'hCAFE : 16'h1111;
         oe_n += int'(mem3_oe);
         check($sformatf("ws3_rv%0d", c), a3_resp_valid, c == 5);
         if (c == 5) check("ws3_rdata", a3_resp_rdata, 16'hCAFE);
         tick();
      end
      check("ws3_oe_cycles", oe_n, 4);

      // reset during ACCESS of a B write
      b_req_valid = 1; b_req_we = 1; b_req_addr = 21'h00040; b_req_wdata = 16'hA5A5;
      #1;
      check("midrst_brdy", b_req_ready, 1);
      tick();
      b_req_valid = 0;
      tick();
      check("midrst_acc_we", mem_we, 1);
      reset = 1'b0;
      tick();
      check("midrst_we", mem_we, 0);
      check("midrst_cs", mem_cs, 0);
      check("midrst_busy", busy, 0);
      check("midrst_brv", b_resp_valid, 0);
      reset = 1'b1;
      tick();
      check("midrst_brv2", b_resp_valid, 0);
      a_req_valid = 1; b_req_valid = 1; b_req_we = 0; a_req_addr = 21'h00010;
      #1;
      check("midrst_ardy", a_req_ready, 1);
      check("midrst_brdy2", b_req_ready, 0);
      b_req_valid = 0;
      tick();
      a_req_valid = 0;
      repeat (3) tick();

      // after an A grant, a reset must restore A's priority for the next contention
      reset = 1'b0;
      tick();
      reset = 1'b1;
      a_req_valid = 1; b_req_valid = 1;
      #1;
      check("lg_ardy", a_req_ready, 1);
      check("lg_brdy", b_req_ready, 0);
      a_req_valid = 0; b_req_valid = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
